// File: rtl/handshake_mon_pkg.sv
// Shared types for the valid/ready protocol monitor.
// Per-channel error vectors are indexed with the ERR_* constants.
package handshake_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } mon_state_e;

  localparam int ERR_DROP = 0;
  localparam int ERR_DATA = 1;
  localparam int ERR_TMO  = 2;
  localparam int NUM_ERR  = 3;

endpackage

// File: rtl/handshake_mon_chan.sv
// One monitored valid/ready channel: IDLE/PEND FSM, payload capture, counters, sticky errors.
// Outputs are registered and reflect the edge that sampled the event; purely passive.
module handshake_mon_chan
  import handshake_mon_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int CH_IDX  = 0
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               en,
  input  logic               clr,
  input  logic               valid_i,
  input  logic               ready_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [NUM_ERR-1:0] err_o,
  output logic [CNT_W-1:0]   xfer_count_o,
  output logic [CNT_W-1:0]   stall_cur_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  mon_state_e         state_q, state_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]   xfer_q, xfer_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [NUM_ERR-1:0] err_q, err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RESETN || clr) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_i && !ready_i) state_d = PEND;
        PEND:    if (!valid_i || ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cap_d   = cap_q;
    xfer_d  = xfer_q;
    stall_d = stall_q;
    err_d   = err_q;
    if (!en) begin
      stall_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_i) begin
            xfer_d = sat_inc(xfer_q);
          end else if (valid_i) begin
            cap_d   = data_i;
            stall_d = CNT_W'(1);
          end
        end
        PEND: begin
          // Compared before acceptance, so a change in the accepting cycle still counts.
          if (data_i != cap_q) err_d[ERR_DATA] = 1'b1;
          if (!valid_i) begin
            err_d[ERR_DROP] = 1'b1;
            stall_d         = '0;
          end else if (ready_i) begin
            xfer_d  = sat_inc(xfer_q);
            stall_d = '0;
          end else begin
            stall_d = sat_inc(stall_q);
            if (stall_d == TMO_VAL) err_d[ERR_TMO] = 1'b1;
          end
        end
        default: stall_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN || clr) begin
      cap_q   <= '0;
      xfer_q  <= '0;
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      cap_q   <= cap_d;
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_o        = err_q;
  assign xfer_count_o = xfer_q;
  assign stall_cur_o  = stall_q;

`ifndef SYNTHESIS
  a_valid_held: assert property (@(posedge CLK) disable iff (!RESETN || !en || clr)
    (state_q == PEND) |-> valid_i)
    else $warning("handshake monitor ch%0d: valid dropped while stalled", CH_IDX);

  a_data_stable: assert property (@(posedge CLK) disable iff (!RESETN || !en || clr)
    (state_q == PEND) |-> (data_i == cap_q))
    else $warning("handshake monitor ch%0d: payload changed while stalled", CH_IDX);

  a_stall_bound: assert property (@(posedge CLK) disable iff (!RESETN || !en || clr)
    (state_q == PEND && valid_i && !ready_i) |-> (stall_q != TMO_VAL - CNT_W'(1)))
    else $warning("handshake monitor ch%0d: stall reached timeout", CH_IDX);
`endif

endmodule

// File: rtl/handshake_rtl_monitor.sv
// Passive protocol monitor over NUM_CH valid/ready channels; never drives the observed design.
// Per-channel outputs follow the sampling edge; err_any lags the sticky flags by one cycle.
module handshake_rtl_monitor
  import handshake_mon_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     en,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        err_valid_drop,
  output logic [NUM_CH-1:0]        err_data_change,
  output logic [NUM_CH-1:0]        err_timeout,
  output logic                     err_any,
  output logic [NUM_CH*CNT_W-1:0]  xfer_count,
  output logic [NUM_CH*CNT_W-1:0]  stall_cur
);

  logic err_any_q, err_any_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [NUM_ERR-1:0] err;

    handshake_mon_chan #(
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W),
      .CH_IDX (i)
    ) u_chan (
      .CLK         (CLK),
      .RESETN      (RESETN),
      .en          (en),
      .clr         (clr),
      .valid_i     (valid[i]),
      .ready_i     (ready[i]),
      .data_i      (data[i*DATA_W +: DATA_W]),
      .err_o       (err),
      .xfer_count_o(xfer_count[i*CNT_W +: CNT_W]),
      .stall_cur_o (stall_cur[i*CNT_W +: CNT_W])
    );

    assign err_valid_drop[i]  = err[ERR_DROP];
    assign err_data_change[i] = err[ERR_DATA];
    assign err_timeout[i]     = err[ERR_TMO];
  end

  assign err_any_d = |{err_valid_drop, err_data_change, err_timeout};

  // Only reset forces err_any low; after clr it follows the flags one cycle later.
  always_ff @(posedge CLK) begin
    if (!RESETN) err_any_q <= 1'b0;
    else         err_any_q <= err_any_d;
  end

  assign err_any = err_any_q;

endmodule

// File: tb/tb_handshake_rtl_monitor.sv
// Directed bench: default-parameter monitor plus a CNT_W=4/TIMEOUT=8 copy sharing the same inputs.
module tb_handshake_rtl_monitor;

  logic        CLK, RESETN, en, clr;
  logic [2:0]  valid, ready;
  logic [11:0] data;

  logic [2:0]  m_vd, m_dc, m_tmo;
  logic        m_any;
  logic [47:0] m_xfer, m_stall;

  logic [2:0]  s_vd, s_dc, s_tmo;
  logic        s_any;
  logic [11:0] s_xfer, s_stall;

  int n_tests = 0;
  int n_fail  = 0;

  handshake_rtl_monitor #(.NUM_CH(3), .DATA_W(4), .TIMEOUT(16), .CNT_W(16)) dut (
    .CLK(CLK), .RESETN(RESETN), .en(en), .clr(clr),
    .valid(valid), .ready(ready), .data(data),
    .err_valid_drop(m_vd), .err_data_change(m_dc), .err_timeout(m_tmo),
    .err_any(m_any), .xfer_count(m_xfer), .stall_cur(m_stall)
  );

  handshake_rtl_monitor #(.NUM_CH(3), .DATA_W(4), .TIMEOUT(8), .CNT_W(4)) dut_s (
    .CLK(CLK), .RESETN(RESETN), .en(en), .clr(clr),
    .valid(valid), .ready(ready), .data(data),
    .err_valid_drop(s_vd), .err_data_change(s_dc), .err_timeout(s_tmo),
    .err_any(s_any), .xfer_count(s_xfer), .stall_cur(s_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; en = 1'b1; clr = 1'b0;
    valid = '0; ready = '0; data = '0;
    tick(); tick();
    n_tests++; if (m_xfer !== '0) begin n_fail++; $display("FAIL reset_xfer: got %h expected 0", m_xfer); end
    n_tests++; if (m_stall !== '0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0", m_stall); end
    n_tests++; if ({m_vd, m_dc, m_tmo} !== 9'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", {m_vd, m_dc, m_tmo}); end
    n_tests++; if (m_any !== 1'b0) begin n_fail++; $display("FAIL reset_err_any: got %b expected 0", m_any); end
    n_tests++; if (s_xfer !== '0) begin n_fail++; $display("FAIL reset_sat_xfer: got %h expected 0", s_xfer); end
    RESETN = 1'b1;
  endtask

  task automatic test_clean();
    valid = 3'b001; ready = 3'b011;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_tests++; if (m_stall !== '0) begin n_fail++; $display("FAIL clean_stall cyc%0d: got %h expected 0", i, m_stall); end
    end
    n_tests++; if (m_xfer[15:0] !== 16'd10) begin n_fail++; $display("FAIL clean_xfer0: got %0d expected 10", m_xfer[15:0]); end
    n_tests++; if (m_xfer[31:16] !== 16'd0) begin n_fail++; $display("FAIL clean_ready_only_ch1: got %0d expected 0", m_xfer[31:16]); end
    n_tests++; if (s_xfer[3:0] !== 4'd10) begin n_fail++; $display("FAIL clean_sat_xfer0: got %0d expected 10", s_xfer[3:0]); end
    n_tests++; if ({m_vd, m_dc, m_tmo, m_any} !== 10'b0) begin n_fail++; $display("FAIL clean_err: got %b expected 0", {m_vd, m_dc, m_tmo, m_any}); end
    valid = '0; ready = '0;
    tick();
  endtask

  task automatic test_valid_drop();
    data[7:4] = 4'h3; valid = 3'b010; ready = 3'b000;
    tick(); tick(); tick();
    n_tests++; if (m_stall[31:16] !== 16'd3) begin n_fail++; $display("FAIL drop_stall: got %0d expected 3", m_stall[31:16]); end
    n_tests++; if (m_vd !== 3'b000) begin n_fail++; $display("FAIL drop_early: got %b expected 000", m_vd); end
    valid = 3'b000;
    tick();
    n_tests++; if (m_vd !== 3'b010) begin n_fail++; $display("FAIL drop_flag: got %b expected 010", m_vd); end
    n_tests++; if (m_stall[31:16] !== 16'd0) begin n_fail++; $display("FAIL drop_stall_clr: got %0d expected 0", m_stall[31:16]); end
    n_tests++; if (m_any !== 1'b0) begin n_fail++; $display("FAIL drop_any_lag: got %b expected 0", m_any); end
    tick();
    n_tests++; if (m_any !== 1'b1) begin n_fail++; $display("FAIL drop_any: got %b expected 1", m_any); end
    n_tests++; if (m_xfer[31:16] !== 16'd0) begin n_fail++; $display("FAIL drop_xfer1: got %0d expected 0", m_xfer[31:16]); end
    n_tests++; if ({m_dc, m_tmo} !== 6'b0) begin n_fail++; $display("FAIL drop_other: got %b expected 0", {m_dc, m_tmo}); end
  endtask

  task automatic test_data_change();
    data[11:8] = 4'hA; valid = 3'b100; ready = 3'b000;
    tick();
    data[11:8] = 4'h5;
    tick();
    n_tests++; if (m_dc !== 3'b100) begin n_fail++; $display("FAIL dchg_flag: got %b expected 100", m_dc); end
    n_tests++; if (m_stall[47:32] !== 16'd2) begin n_fail++; $display("FAIL dchg_stall: got %0d expected 2", m_stall[47:32]); end
    ready = 3'b100;
    tick();
    n_tests++; if (m_xfer[47:32] !== 16'd1) begin n_fail++; $display("FAIL dchg_xfer2: got %0d expected 1", m_xfer[47:32]); end
    n_tests++; if (m_stall[47:32] !== 16'd0) begin n_fail++; $display("FAIL dchg_stall_rel: got %0d expected 0", m_stall[47:32]); end
    n_tests++; if (m_dc !== 3'b100) begin n_fail++; $display("FAIL dchg_sticky: got %b expected 100", m_dc); end
    valid = '0; ready = '0;
    tick();
  endtask

  task automatic test_timeout();
    clr = 1'b1; tick(); clr = 1'b0;
    data[3:0] = 4'h1; valid = 3'b001; ready = 3'b000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_tests++; if (m_stall[15:0] !== 16'(i)) begin n_fail++; $display("FAIL tmo_stall cyc%0d: got %0d expected %0d", i, m_stall[15:0], i); end
      n_tests++; if (m_tmo[0] !== (i >= 16)) begin n_fail++; $display("FAIL tmo_flag cyc%0d: got %b expected %b", i, m_tmo[0], (i >= 16)); end
      n_tests++; if (s_stall[3:0] !== 4'((i > 15) ? 15 : i)) begin n_fail++; $display("FAIL tmo_sat_stall cyc%0d: got %0d", i, s_stall[3:0]); end
      n_tests++; if (s_tmo[0] !== (i >= 8)) begin n_fail++; $display("FAIL tmo_sat_flag cyc%0d: got %b expected %b", i, s_tmo[0], (i >= 8)); end
    end
    ready = 3'b001;
    tick();
    n_tests++; if (m_xfer[15:0] !== 16'd1) begin n_fail++; $display("FAIL tmo_xfer: got %0d expected 1", m_xfer[15:0]); end
    n_tests++; if (m_stall[15:0] !== 16'd0) begin n_fail++; $display("FAIL tmo_stall_rel: got %0d expected 0", m_stall[15:0]); end
    n_tests++; if (m_tmo !== 3'b001) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 001", m_tmo); end
    n_tests++; if (m_vd !== 3'b000) begin n_fail++; $display("FAIL tmo_no_drop: got %b expected 000", m_vd); end
    n_tests++; if (s_xfer[3:0] !== 4'd1) begin n_fail++; $display("FAIL tmo_sat_xfer: got %0d expected 1", s_xfer[3:0]); end
    valid = '0; ready = '0;
    tick();
  endtask

  task automatic test_sat_en_clr();
    clr = 1'b1; tick(); clr = 1'b0;
    valid = 3'b001; ready = 3'b001;
    repeat (20) tick();
    n_tests++; if (s_xfer[3:0] !== 4'd15) begin n_fail++; $display("FAIL sat_xfer: got %0d expected 15", s_xfer[3:0]); end
    n_tests++; if (m_xfer[15:0] !== 16'd20) begin n_fail++; $display("FAIL sat_main_xfer: got %0d expected 20", m_xfer[15:0]); end
    en = 1'b0; valid = 3'b111; ready = 3'b101;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_tests++; if (m_stall !== '0) begin n_fail++; $display("FAIL en_stall cyc%0d: got %h expected 0", i, m_stall); end
    end
    n_tests++; if (m_xfer[15:0] !== 16'd20) begin n_fail++; $display("FAIL en_hold_main: got %0d expected 20", m_xfer[15:0]); end
    n_tests++; if (s_xfer[3:0] !== 4'd15) begin n_fail++; $display("FAIL en_hold_sat: got %0d expected 15", s_xfer[3:0]); end
    n_tests++; if (m_xfer[47:32] !== 16'd0) begin n_fail++; $display("FAIL en_hold_ch2: got %0d expected 0", m_xfer[47:32]); end
    en = 1'b1; valid = '0; ready = '0;
    tick();
    n_tests++; if (m_vd !== 3'b000) begin n_fail++; $display("FAIL en_no_drop: got %b expected 000", m_vd); end
    valid = 3'b010; tick();
    valid = 3'b000; tick(); tick();
    n_tests++; if (m_any !== 1'b1) begin n_fail++; $display("FAIL clr_pre_any: got %b expected 1", m_any); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_tests++; if ({m_vd, m_dc, m_tmo} !== 9'b0) begin n_fail++; $display("FAIL clr_err: got %b expected 0", {m_vd, m_dc, m_tmo}); end
    n_tests++; if ({s_vd, s_dc, s_tmo} !== 9'b0) begin n_fail++; $display("FAIL clr_sat_err: got %b expected 0", {s_vd, s_dc, s_tmo}); end
    n_tests++; if (m_xfer !== '0 || s_xfer !== '0) begin n_fail++; $display("FAIL clr_xfer: got %h/%h expected 0", m_xfer, s_xfer); end
    n_tests++; if (m_stall !== '0 || s_stall !== '0) begin n_fail++; $display("FAIL clr_stall: got %h/%h expected 0", m_stall, s_stall); end
    tick();
    n_tests++; if (m_any !== 1'b0 || s_any !== 1'b0) begin n_fail++; $display("FAIL clr_any: got %b/%b expected 0", m_any, s_any); end
  endtask

  task automatic test_reset_mid_stall();
    data[7:4] = 4'h7; valid = 3'b010; ready = 3'b000;
    repeat (5) tick();
    n_tests++; if (m_stall[31:16] !== 16'd5) begin n_fail++; $display("FAIL rst_pre_stall: got %0d expected 5", m_stall[31:16]); end
    RESETN = 1'b0; tick(); RESETN = 1'b1;
    n_tests++; if (m_stall !== '0) begin n_fail++; $display("FAIL rst_stall: got %h expected 0", m_stall); end
    valid = 3'b000;
    tick();
    n_tests++; if (m_vd !== 3'b000) begin n_fail++; $display("FAIL rst_no_drop: got %b expected 000", m_vd); end
    tick();
    n_tests++; if (m_any !== 1'b0) begin n_fail++; $display("FAIL rst_any: got %b expected 0", m_any); end
    valid = 3'b010;
    tick();
    n_tests++; if (m_stall[31:16] !== 16'd1) begin n_fail++; $display("FAIL rst_idle_restart: got %0d expected 1", m_stall[31:16]); end
    ready = 3'b010;
    tick();
    n_tests++; if (m_xfer[31:16] !== 16'd1) begin n_fail++; $display("FAIL rst_accept: got %0d expected 1", m_xfer[31:16]); end
    n_tests++; if (m_vd !== 3'b000) begin n_fail++; $display("FAIL rst_accept_nodrop: got %b expected 000", m_vd); end
    valid = '0; ready = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_valid_drop();
    test_data_change();
    test_timeout();
    test_sat_en_clr();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
